otp_readout_seq: RTL and testbench

//  Command-side initiator for the OTP macro ready/valid interface (the macro is the responder).

---
 rtl/otp_readout_seq.sv | 225 ++++++++++++++++++++++
 tb/tb_otp_readout_seq.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/otp_readout_seq.sv
// Power-up readout engine for the OTP macro: one Init, then NumBeats Read commands,
// each returned beat handed to a consumer over valid/ready. Never issues writes.

package otp_ctrl_pkg;
    parameter int OtpCmdWidth = 2;
    parameter int OtpErrWidth = 3;

    typedef enum logic [OtpCmdWidth-1:0] {
        OtpRead  = 2'b00,
        OtpWrite = 2'b01,
        OtpInit  = 2'b11
    } cmd_e;

    typedef enum logic [OtpErrWidth-1:0] {
        NoErr            = 3'h0,
        OtpCmdInvErr     = 3'h1,
        OtpInitErr       = 3'h2,
        OtpReadErr       = 3'h3,
        OtpReadUncorrErr = 3'h4,
        OtpReadCorrErr   = 3'h5,
        OtpWriteBlankErr = 3'h6,
        OtpWriteErr      = 3'h7
    } err_e;
endpackage

module otp_readout_seq
    import otp_ctrl_pkg::*;
#(
    parameter int Width         = 16,
    parameter int SizeWidth     = 2,
    parameter int AddrWidth     = 10,
    parameter int CmdWidth      = OtpCmdWidth,
    parameter int ErrWidth      = OtpErrWidth,
    parameter int NumBeats      = 8,
    parameter int ReadSize      = 3,
    parameter int BaseAddr      = 0,
    parameter int TimeoutCycles = 1024,
    localparam int IfWidth      = (2**SizeWidth) * Width,
    localparam int IdxWidth     = (NumBeats > 1) ? $clog2(NumBeats) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [ErrWidth-1:0]  err_o,
    output logic                 timeout_o,
    input  logic                 otp_ready_i,
    output logic                 otp_valid_o,
    output logic [SizeWidth-1:0] otp_size_o,
    output logic [CmdWidth-1:0]  otp_cmd_o,
    output logic [AddrWidth-1:0] otp_addr_o,
    output logic [IfWidth-1:0]   otp_wdata_o,
    input  logic                 otp_valid_i,
    input  logic [IfWidth-1:0]   otp_rdata_i,
    input  logic [ErrWidth-1:0]  otp_err_i,
    output logic                 data_valid_o,
    input  logic                 data_ready_i,
    output logic [IfWidth-1:0]   data_o,
    output logic [IdxWidth-1:0]  data_idx_o,
    output logic                 data_corr_o
);

    localparam int CntWidth = $clog2(TimeoutCycles + 1);

    if (NumBeats < 1 || TimeoutCycles < 2 ||
        BaseAddr + NumBeats * (ReadSize + 1) > 2**AddrWidth) begin : gen_param_check
        $error("otp_readout_seq: readout window or parameters out of range");
    end

    // Codewords of a [10,3,5] linear code: any two states differ in at least 5 bits.
    typedef enum logic [9:0] {
        IdleSt     = 10'b0000000000,
        InitReqSt  = 10'b0011010101,
        InitWaitSt = 10'b0100110011,
        ReadReqSt  = 10'b0111100110,
        ReadWaitSt = 10'b1000001111,
        PushSt     = 10'b1011011010,
        DoneSt     = 10'b1100111100,
        ErrorSt    = 10'b1111101001
    } state_e;

    state_e                state_q, state_d;
    logic [IdxWidth-1:0]   beat_q, beat_d;
    logic [CntWidth-1:0]   cnt_q, cnt_d;
    logic                  done_q, done_d;
    logic [ErrWidth-1:0]   err_q, err_d;
    logic                  timeout_q, timeout_d;
    logic [IfWidth-1:0]    data_q, data_d;
    logic [IdxWidth-1:0]   idx_q, idx_d;
    logic                  corr_q, corr_d;

    logic                  busy, cmd_valid, push_valid;
    logic [CmdWidth-1:0]   cmd;
    logic [AddrWidth-1:0]  addr;
    logic [AddrWidth-1:0]  read_addr;
    logic [CntWidth-1:0]   cnt_inc;

    assign read_addr = AddrWidth'(BaseAddr) + AddrWidth'(beat_q) * AddrWidth'(ReadSize + 1);
    assign cnt_inc   = cnt_q + CntWidth'(1);

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can infer a latch.
        state_d    = state_q;
        beat_d     = beat_q;
        cnt_d      = '0;
        done_d     = done_q;
        err_d      = err_q;
        timeout_d  = timeout_q;
        data_d     = data_q;
        idx_d      = idx_q;
        corr_d     = corr_q;
        busy       = 1'b0;
        cmd_valid  = 1'b0;
        push_valid = 1'b0;
        cmd        = '0;
        addr       = '0;

        unique case (state_q)
            IdleSt: begin
                if (start_i) state_d = InitReqSt;
            end
            InitReqSt: begin
                busy      = 1'b1;
                cmd_valid = 1'b1;
                cmd       = CmdWidth'(OtpInit);
                if (otp_ready_i) state_d = InitWaitSt;
            end
            ReadReqSt: begin
                busy      = 1'b1;
                cmd_valid = 1'b1;
                cmd       = CmdWidth'(OtpRead);
                addr      = read_addr;
                if (otp_ready_i) state_d = ReadWaitSt;
            end
            InitWaitSt, ReadWaitSt: begin
                busy = 1'b1;
                // A response in the expiry cycle takes priority over the watchdog.
                if (otp_valid_i) begin
                    if (state_q == InitWaitSt) begin
                        if (otp_err_i == ErrWidth'(NoErr)) begin
                            state_d = ReadReqSt;
                        end else begin
                            err_d   = otp_err_i;
                            state_d = ErrorSt;
                        end
                    end else if (otp_err_i == ErrWidth'(NoErr) ||
                                 otp_err_i == ErrWidth'(OtpReadCorrErr)) begin
                        data_d  = otp_rdata_i;
                        corr_d  = (otp_err_i == ErrWidth'(OtpReadCorrErr));
                        idx_d   = beat_q;
                        state_d = PushSt;
                    end else begin
                        err_d   = otp_err_i;
                        state_d = ErrorSt;
                    end
                end else if (cnt_inc == CntWidth'(TimeoutCycles)) begin
                    timeout_d = 1'b1;
                    state_d   = ErrorSt;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            PushSt: begin
                busy       = 1'b1;
                push_valid = 1'b1;
                if (data_ready_i) begin
                    if (beat_q == IdxWidth'(NumBeats - 1)) begin
                        done_d  = 1'b1;
                        state_d = DoneSt;
                    end else begin
                        beat_d  = beat_q + IdxWidth'(1);
                        state_d = ReadReqSt;
                    end
                end
            end
            DoneSt, ErrorSt: begin
            end
            default: begin
                err_d   = ErrWidth'(OtpCmdInvErr);
                state_d = ErrorSt;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        // NOTE: state registers take non-blocking assignments so every flop samples pre-edge values.
        if (!rst_ni) begin
            state_q   <= IdleSt;
            beat_q    <= '0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            err_q     <= ErrWidth'(NoErr);
            timeout_q <= 1'b0;
            data_q    <= '0;
            idx_q     <= '0;
            corr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
            err_q     <= err_d;
            timeout_q <= timeout_d;
            data_q    <= data_d;
            idx_q     <= idx_d;
            corr_q    <= corr_d;
        end
    end

    assign busy_o       = busy;
    assign done_o       = done_q;
    assign err_o        = err_q;
    assign timeout_o    = timeout_q;
    assign otp_valid_o  = cmd_valid;
    assign otp_size_o   = SizeWidth'(ReadSize);
    assign otp_cmd_o    = cmd;
    assign otp_addr_o   = addr;
    assign otp_wdata_o  = '0;
    assign data_valid_o = push_valid;
    assign data_o       = data_q;
    assign data_idx_o   = idx_q;
    assign data_corr_o  = corr_q;

endmodule

// File: tb/tb_otp_readout_seq.sv
// Directed bench for otp_readout_seq: a scripted macro responder and consumer drive each
// scenario, with expected command fields, beats and sticky status computed by hand.

module tb_otp_readout_seq;
    import otp_ctrl_pkg::*;

    localparam int NumBeats      = 2;
    localparam int ReadSize      = 3;
    localparam int BaseAddr      = 'h10;
    localparam int TimeoutCycles = 16;
    localparam int IfWidth       = 64;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start;
    logic               busy_o, done_o, timeout_o;
    logic [2:0]         err_o;
    logic               otp_ready;
    logic               otp_valid_o;
    logic [1:0]         otp_size_o;
    logic [1:0]         otp_cmd_o;
    logic [9:0]         otp_addr_o;
    logic [IfWidth-1:0] otp_wdata_o;
    logic               otp_valid;
    logic [IfWidth-1:0] otp_rdata;
    logic [2:0]         otp_err;
    logic               data_valid_o;
    logic               data_ready;
    logic [IfWidth-1:0] data_o;
    logic [0:0]         data_idx_o;
    logic               data_corr_o;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    otp_readout_seq #(
        .NumBeats      (NumBeats),
        .ReadSize      (ReadSize),
        .BaseAddr      (BaseAddr),
        .TimeoutCycles (TimeoutCycles)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .start_i      (start),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o),
        .timeout_o    (timeout_o),
        .otp_ready_i  (otp_ready),
        .otp_valid_o  (otp_valid_o),
        .otp_size_o   (otp_size_o),
        .otp_cmd_o    (otp_cmd_o),
        .otp_addr_o   (otp_addr_o),
        .otp_wdata_o  (otp_wdata_o),
        .otp_valid_i  (otp_valid),
        .otp_rdata_i  (otp_rdata),
        .otp_err_i    (otp_err),
        .data_valid_o (data_valid_o),
        .data_ready_i (data_ready),
        .data_o       (data_o),
        .data_idx_o   (data_idx_o),
        .data_corr_o  (data_corr_o)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] beat_data(input int run, input int k);
        return 64'hF00D_0000_0000_0000 | (64'(run) << 20) | (64'(k) << 8) | 64'h3C;
    endfunction

    task automatic do_reset();
        rst_n      = 1'b0;
        start      = 1'b0;
        otp_ready  = 1'b0;
        otp_valid  = 1'b0;
        otp_rdata  = '0;
        otp_err    = '0;
        data_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic kick();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Waits for a command, holds it off one cycle, then accepts it.
    task automatic accept_cmd(input string tag, input logic [1:0] exp_cmd, input logic [9:0] exp_addr);
        for (int i = 0; i < 20 && otp_valid_o !== 1'b1; i++) @(negedge clk);
        check({tag, ".valid"}, otp_valid_o, 1);
        check({tag, ".cmd"}, otp_cmd_o, exp_cmd);
        check({tag, ".addr"}, otp_addr_o, exp_addr);
        check({tag, ".size"}, otp_size_o, 3);
        @(negedge clk);
        check({tag, ".hold"}, {otp_valid_o, otp_cmd_o, otp_addr_o}, {1'b1, exp_cmd, exp_addr});
        otp_ready = 1'b1;
        @(negedge clk);
        otp_ready = 1'b0;
        check({tag, ".drop"}, otp_valid_o, 0);
    endtask

    task automatic respond(input int delay, input logic [2:0] err, input logic [63:0] rdata);
        repeat (delay) @(negedge clk);
        otp_valid = 1'b1;
        otp_err   = err;
        otp_rdata = rdata;
        @(negedge clk);
        otp_valid = 1'b0;
        otp_err   = '0;
        otp_rdata = '0;
    endtask

    // Waits for a beat, stalls it, pokes stray inputs that must be ignored, then pops it.
    task automatic take_beat(input string tag, input int idx, input logic [63:0] exp_data,
                             input logic exp_corr, input int stall);
        for (int i = 0; i < 20 && data_valid_o !== 1'b1; i++) @(negedge clk);
        check({tag, ".valid"}, data_valid_o, 1);
        check({tag, ".idx"}, data_idx_o, 64'(idx));
        check({tag, ".data"}, data_o, exp_data);
        check({tag, ".corr"}, data_corr_o, exp_corr);
        for (int i = 0; i < stall; i++) begin
            if (i == 2) begin
                otp_valid = 1'b1;
                otp_rdata = ~exp_data;
                otp_err   = 3'(NoErr);
            end
            start = (i == 3);
            @(negedge clk);
            otp_valid = 1'b0;
            otp_rdata = '0;
            start     = 1'b0;
            check({tag, ".stall_flags"}, {data_valid_o, otp_valid_o, data_idx_o, data_corr_o},
                  {1'b1, 1'b0, 1'(idx), exp_corr});
            check({tag, ".stall_data"}, data_o, exp_data);
        end
        data_ready = 1'b1;
        @(negedge clk);
        data_ready = 1'b0;
        check({tag, ".pop"}, data_valid_o, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "bench time limit");
    end

    initial begin
        logic seen;

        // Reset state, then a clean two-beat readout with a stalled consumer on beat 0.
        do_reset();
        check("rst.flags", {busy_o, done_o, err_o, timeout_o, otp_valid_o, data_valid_o,
                            data_corr_o, data_idx_o}, 0);
        check("rst.data", data_o, 0);
        check("rst.wdata", otp_wdata_o, 0);
        kick();
        accept_cmd("t1.init", OtpInit, 10'h000);
        respond(0, NoErr, '0);
        accept_cmd("t1.rd0", OtpRead, 10'h010);
        respond(1, NoErr, beat_data(1, 0));
        take_beat("t1.b0", 0, beat_data(1, 0), 1'b0, 5);
        accept_cmd("t1.rd1", OtpRead, 10'h014);
        respond(2, NoErr, beat_data(1, 1));
        take_beat("t1.b1", 1, beat_data(1, 1), 1'b0, 0);
        check("t1.end", {busy_o, done_o, err_o, timeout_o}, {1'b0, 1'b1, 3'b000, 1'b0});
        kick();
        @(negedge clk);
        check("t1.sticky", {busy_o, otp_valid_o, done_o}, {1'b0, 1'b0, 1'b1});

        // Init rejected: no Read may follow.
        do_reset();
        kick();
        accept_cmd("t3.init", OtpInit, 10'h000);
        respond(0, OtpCmdInvErr, '0);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            seen |= otp_valid_o;
            @(negedge clk);
        end
        check("t3.no_read", seen, 0);
        check("t3.end", {busy_o, done_o, err_o, timeout_o}, {1'b0, 1'b0, 3'h1, 1'b0});

        // Uncorrectable error on beat 1: only beat 0 delivered.
        do_reset();
        kick();
        accept_cmd("t4.init", OtpInit, 10'h000);
        respond(0, NoErr, '0);
        accept_cmd("t4.rd0", OtpRead, 10'h010);
        respond(0, NoErr, beat_data(4, 0));
        take_beat("t4.b0", 0, beat_data(4, 0), 1'b0, 0);
        accept_cmd("t4.rd1", OtpRead, 10'h014);
        respond(0, OtpReadUncorrErr, beat_data(4, 1));
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            seen |= otp_valid_o | data_valid_o;
            @(negedge clk);
        end
        check("t4.no_more", seen, 0);
        check("t4.end", {busy_o, done_o, err_o, timeout_o}, {1'b0, 1'b0, 3'h4, 1'b0});
        check("t4.data_kept", data_o, beat_data(4, 0));

        // Corrected beat 0; beat 1 answered in the last wait cycle before expiry.
        do_reset();
        kick();
        accept_cmd("t5.init", OtpInit, 10'h000);
        respond(0, NoErr, '0);
        accept_cmd("t5.rd0", OtpRead, 10'h010);
        respond(0, OtpReadCorrErr, beat_data(5, 0));
        take_beat("t5.b0", 0, beat_data(5, 0), 1'b1, 0);
        accept_cmd("t5.rd1", OtpRead, 10'h014);
        respond(TimeoutCycles - 1, NoErr, beat_data(5, 1));
        take_beat("t5.b1", 1, beat_data(5, 1), 1'b0, 0);
        check("t5.end", {busy_o, done_o, err_o, timeout_o}, {1'b0, 1'b1, 3'b000, 1'b0});

        // Silent macro: timeout exactly TimeoutCycles cycles after entering the wait.
        do_reset();
        kick();
        accept_cmd("t6.init", OtpInit, 10'h000);
        respond(0, NoErr, '0);
        accept_cmd("t6.rd0", OtpRead, 10'h010);
        seen = 1'b0;
        for (int i = 1; i < TimeoutCycles; i++) begin
            @(negedge clk);
            seen |= timeout_o;
        end
        check("t6.early", seen, 0);
        @(negedge clk);
        check("t6.timeout", timeout_o, 1);
        check("t6.end", {busy_o, done_o, err_o, otp_valid_o}, {1'b0, 1'b0, 3'b000, 1'b0});

        // Reset in the middle of a read wait clears everything; a late response is ignored.
        do_reset();
        kick();
        accept_cmd("t7.init", OtpInit, 10'h000);
        respond(0, NoErr, '0);
        accept_cmd("t7.rd0", OtpRead, 10'h010);
        respond(0, OtpReadCorrErr, beat_data(7, 0));
        take_beat("t7.b0", 0, beat_data(7, 0), 1'b1, 0);
        accept_cmd("t7.rd1", OtpRead, 10'h014);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("t7.rst_flags", {busy_o, done_o, err_o, timeout_o, otp_valid_o, otp_cmd_o,
                               otp_addr_o, data_valid_o, data_corr_o, data_idx_o}, 0);
        check("t7.rst_data", data_o, 0);
        rst_n = 1'b1;
        respond(0, NoErr, beat_data(7, 1));
        @(negedge clk);
        check("t7.late_flags", {busy_o, data_valid_o, otp_valid_o, done_o}, 0);
        check("t7.late_data", data_o, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
